// File: rtl/enigma_out_collector.sv
// enigma_out_collector: captures a counted run of enigma symbols, then drains them in order over valid/ready
module enigma_out_collector #(
    parameter int SYMB_W = 6,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CNT_W-1:0]  symb_numb_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [SYMB_W-1:0] in_symb_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SYMB_W-1:0] out_symb_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              drop_o,
    output logic [CNT_W-1:0]  cnt_o
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
    state_t state_q, state_d;
    logic [SYMB_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q, target_q;
    logic done_q, drop_q, start_ok, wr_en, rd_en, last_wr, last_rd;
    // next-state: the write pointer doubles as the capture count
    always_comb begin
        start_ok = state_q == IDLE && start_i;
        wr_en    = state_q == CAPTURE && in_valid_i;
        rd_en    = state_q == DRAIN && out_ready_i;
        last_wr  = CNT_W'(wr_ptr_q + 1'b1) == target_q;
        last_rd  = CNT_W'(rd_ptr_q + 1'b1) == target_q;
        state_d  = state_q;
        if (start_ok && symb_numb_i != '0) state_d = CAPTURE;
        if (wr_en && last_wr) state_d = DRAIN;
        if (rd_en && last_rd) state_d = IDLE;
    end
    // state, pointers and pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (start_ok && symb_numb_i == '0) || (wr_en && last_wr);
            drop_q  <= in_valid_i && state_q != CAPTURE;
            if (start_ok && symb_numb_i != '0) begin
                target_q <= symb_numb_i;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
    // buffer storage is left untouched by reset
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= in_symb_i;
    end
    assign out_valid_o = state_q == DRAIN;
    assign out_symb_o  = out_valid_o ? mem[rd_ptr_q] : '0;
    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign drop_o      = drop_q;
    assign cnt_o       = wr_ptr_q;
endmodule
